// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller between one L1 cache array and the shared memory port.
// It refills a multi-word line using a word counter. With WRITEBACK=1 it first
// writes back a dirty victim line. It keeps a saturating count of accepted misses
// and uses busy/other_busy to share the memory port with the other controller.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req, hit                access valid / tag match for this cycle
//   dirty                   victim line dirty (only used when WRITEBACK=1)
//   miss_addr, victim_addr  word addresses of the access and of the victim line
//   other_busy              other controller owns memory
//   mem_rdy                 memory finished the current word
//   mem_re, mem_we          memory read / write enable
//   mem_addr                memory word address {line base, word counter}
//   word_sel                word index into the cache data array
//   cache_we, tag_we        data array write / tag+valid write (clears dirty)
//   stall                   pipeline stall
//   busy                    this controller owns memory
//   miss_cnt                saturating count of accepted misses
module cache_refill_ctrl #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned WRITEBACK      = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req,
  input  logic                              hit,
  input  logic                              dirty,
  input  logic [ADDR_W-1:0]                 miss_addr,
  input  logic [ADDR_W-1:0]                 victim_addr,
  input  logic                              other_busy,
  input  logic                              mem_rdy,
  output logic                              mem_re,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_sel,
  output logic                              cache_we,
  output logic                              tag_we,
  output logic                              stall,
  output logic                              busy,
  output logic [CNT_W-1:0]                  miss_cnt
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned BASE_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [OFF_W-1:0]    cnt, cnt_nx;
  logic [BASE_W-1:0]   line_q, victim_q;
  logic                accept;

  // The in-line word offsets are replaced by the counter and never read.
  logic unused_offsets;
  assign unused_offsets = ^{miss_addr[OFF_W-1:0], victim_addr[OFF_W-1:0]};

  // State, word counter, latched line bases and the miss counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      line_q   <= '0;
      victim_q <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        line_q   <= miss_addr[ADDR_W-1:OFF_W];
        victim_q <= victim_addr[ADDR_W-1:OFF_W];
        if (miss_cnt != {CNT_W{1'b1}}) begin
          miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Next state and outputs. The outputs are combinational so the stall can rise
  // in the cycle the miss is seen. Gating them with rst_n keeps them at 0 while
  // reset is held.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    word_sel = '0;
    cache_we = 1'b0;
    tag_we   = 1'b0;
    stall    = 1'b0;
    busy     = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            // A blocked miss stalls and retries each cycle without being counted.
            stall = 1'b1;
            if (!other_busy) begin
              accept   = 1'b1;
              busy     = 1'b1;
              cnt_nx   = '0;
              state_nx = ((WRITEBACK != 0) && dirty) ? WB : FILL;
            end
          end
        end
        WB: begin
          stall    = 1'b1;
          busy     = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {victim_q, cnt};
          word_sel = cnt;
          if (mem_rdy) begin
            cnt_nx = cnt + OFF_W'(1);
            if (cnt == LAST_WORD) begin
              cnt_nx   = '0;
              state_nx = FILL;
            end
          end
        end
        FILL: begin
          stall    = 1'b1;
          busy     = 1'b1;
          mem_re   = 1'b1;
          mem_addr = {line_q, cnt};
          word_sel = cnt;
          if (mem_rdy) begin
            cache_we = 1'b1;
            cnt_nx   = cnt + OFF_W'(1);
            if (cnt == LAST_WORD) begin
              tag_we   = 1'b1;
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req, hit, dirty, other_busy, mem_rdy;
  logic [15:0] miss_addr, victim_addr;

  // dut0: I-cache style, dut1: writeback, dut2: 2-bit miss counter
  logic        re0, we0, cwe0, twe0, st0, bz0;
  logic        re1, we1, cwe1, twe1, st1, bz1;
  logic        re2, we2, cwe2, twe2, st2, bz2;
  logic [15:0] a0, a1, a2;
  logic [1:0]  s0, s1, s2;
  logic [15:0] mc0, mc1;
  logic [1:0]  mc2;

  cache_refill_ctrl #(.WORDS_PER_LINE(4), .ADDR_W(16), .WRITEBACK(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .hit(hit), .dirty(dirty),
    .miss_addr(miss_addr), .victim_addr(victim_addr), .other_busy(other_busy),
    .mem_rdy(mem_rdy), .mem_re(re0), .mem_we(we0), .mem_addr(a0), .word_sel(s0),
    .cache_we(cwe0), .tag_we(twe0), .stall(st0), .busy(bz0), .miss_cnt(mc0));

  cache_refill_ctrl #(.WORDS_PER_LINE(4), .ADDR_W(16), .WRITEBACK(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .hit(hit), .dirty(dirty),
    .miss_addr(miss_addr), .victim_addr(victim_addr), .other_busy(other_busy),
    .mem_rdy(mem_rdy), .mem_re(re1), .mem_we(we1), .mem_addr(a1), .word_sel(s1),
    .cache_we(cwe1), .tag_we(twe1), .stall(st1), .busy(bz1), .miss_cnt(mc1));

  cache_refill_ctrl #(.WORDS_PER_LINE(4), .ADDR_W(16), .WRITEBACK(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .hit(hit), .dirty(dirty),
    .miss_addr(miss_addr), .victim_addr(victim_addr), .other_busy(other_busy),
    .mem_rdy(mem_rdy), .mem_re(re2), .mem_we(we2), .mem_addr(a2), .word_sel(s2),
    .cache_we(cwe2), .tag_we(twe2), .stall(st2), .busy(bz2), .miss_cnt(mc2));

  // Packed output view: {stall, busy, re, we, addr[15:0], sel[1:0], cache_we, tag_we}
  logic [23:0] o0, o1, o2;
  assign o0 = {st0, bz0, re0, we0, a0, s0, cwe0, twe0};
  assign o1 = {st1, bz1, re1, we1, a1, s1, cwe1, twe1};
  assign o2 = {st2, bz2, re2, we2, a2, s2, cwe2, twe2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ov(input logic s, input logic b, input logic r,
                                     input logic w, input logic [15:0] a,
                                     input logic [1:0] sel, input logic c, input logic t);
    return {s, b, r, w, a, sel, c, t};
  endfunction

  typedef struct {
    logic        req, hit, dirty, ob, rdy;
    logic [15:0] ma;
    logic [23:0] exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rq, input logic h, input logic d, input logic ob,
                     input logic rdy, input logic [15:0] ma, input logic [23:0] e,
                     input logic [15:0] c);
    vec_t v;
    v.req = rq; v.hit = h; v.dirty = d; v.ob = ob; v.rdy = rdy;
    v.ma = ma; v.exp = e; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    req = 1'b0; hit = 1'b0; dirty = 1'b0; other_busy = 1'b0; mem_rdy = 1'b0;
    miss_addr = 16'h0000; victim_addr = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    req = 1'b1;  // a pending miss must not show through while in reset
    @(negedge clk);
    #1;
    chk("reset_o0", 32'(o0), 32'h0);
    chk("reset_o1", 32'(o1), 32'h0);
    chk("reset_o2", 32'(o2), 32'h0);
    chk("reset_cnt0", 32'(mc0), 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Refill of 0x0123 with mem_rdy 3,5,6,9 cycles after accept; req drops mid-fill.
    add(1,0,0,0,0, 16'h0123, ov(1,1,0,0,16'h0000,0,0,0), 0);
    add(1,0,0,0,0, 16'h0123, ov(1,1,1,0,16'h0120,0,0,0), 1);
    add(1,0,0,0,0, 16'h0123, ov(1,1,1,0,16'h0120,0,0,0), 1);
    add(1,0,0,0,1, 16'h0123, ov(1,1,1,0,16'h0120,0,1,0), 1);
    add(1,0,0,0,0, 16'h0123, ov(1,1,1,0,16'h0121,1,0,0), 1);
    add(1,0,0,0,1, 16'h0123, ov(1,1,1,0,16'h0121,1,1,0), 1);
    add(1,0,0,0,1, 16'h0123, ov(1,1,1,0,16'h0122,2,1,0), 1);
    add(0,0,0,0,0, 16'h0123, ov(1,1,1,0,16'h0123,3,0,0), 1);
    add(1,0,0,0,0, 16'h0123, ov(1,1,1,0,16'h0123,3,0,0), 1);
    add(1,0,0,0,1, 16'h0123, ov(1,1,1,0,16'h0123,3,1,1), 1);
    // Replayed access hits (dirty ignored); mem_rdy in IDLE is ignored.
    add(1,1,1,0,0, 16'h0123, ov(0,0,0,0,16'h0000,0,0,0), 1);
    add(0,0,0,0,1, 16'h0123, ov(0,0,0,0,16'h0000,0,0,0), 1);
    // Miss blocked by other_busy for 5 cycles, accepted on the 6th.
    for (int i = 0; i < 5; i++)
      add(1,0,1,1,0, 16'h0F07, ov(1,0,0,0,16'h0000,0,0,0), 1);
    add(1,0,1,0,0, 16'h0F07, ov(1,1,0,0,16'h0000,0,0,0), 1);
    // Address changes after accept are ignored; dirty does not trigger writeback.
    add(0,0,0,0,1, 16'hFFFF, ov(1,1,1,0,16'h0F04,0,1,0), 2);
    add(1,0,0,0,1, 16'hFFFF, ov(1,1,1,0,16'h0F05,1,1,0), 2);
    add(1,0,0,0,1, 16'hFFFF, ov(1,1,1,0,16'h0F06,2,1,0), 2);
    add(1,0,0,1,1, 16'hFFFF, ov(1,1,1,0,16'h0F07,3,1,1), 2);
    add(1,1,0,0,0, 16'h0F07, ov(0,0,0,0,16'h0000,0,0,0), 2);

    foreach (tbl[i]) begin
      req = tbl[i].req; hit = tbl[i].hit; dirty = tbl[i].dirty;
      other_busy = tbl[i].ob; mem_rdy = tbl[i].rdy; miss_addr = tbl[i].ma;
      #1;
      chk($sformatf("vec%0d_out", i), 32'(o0), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(mc0), 32'(tbl[i].cnt));
      @(negedge clk);
    end

    // Writeback of victim 0x0440 then refill of 0x0810, mem_rdy every other cycle.
    do_reset();
    req = 1'b1; hit = 1'b0; dirty = 1'b1;
    miss_addr = 16'h0810; victim_addr = 16'h0440;
    #1;
    chk("wb_accept", 32'(o1), 32'(ov(1,1,0,0,16'h0000,0,0,0)));
    @(negedge clk);
    req = 1'b0; dirty = 1'b0; miss_addr = 16'h1234; victim_addr = 16'h7777;
    for (int ph = 0; ph < 2; ph++) begin
      for (int w = 0; w < 4; w++) begin
        for (int r = 0; r < 2; r++) begin
          logic [15:0] base;
          base = (ph == 1) ? 16'h0810 : 16'h0440;
          mem_rdy = 1'(r);
          #1;
          chk($sformatf("wb_p%0d_w%0d_r%0d", ph, w, r), 32'(o1),
              32'(ov(1, 1, 1'(ph), 1'(ph == 0), 16'(base + 16'(w)), 2'(w),
                     1'(ph == 1 && r == 1), 1'(ph == 1 && r == 1 && w == 3))));
          chk("wb_exclusive", 32'(re1 & we1), 32'h0);
          @(negedge clk);
        end
      end
    end
    mem_rdy = 1'b0;
    #1;
    chk("wb_done", 32'(o1), 32'h0);
    chk("wb_cnt", 32'(mc1), 32'h1);

    // Reset during FILL at word 2: outputs clear at once, no tag_we, clean restart.
    do_reset();
    req = 1'b1; hit = 1'b0; miss_addr = 16'h0123;
    @(negedge clk);
    req = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_w2", 32'(o0), 32'(ov(1,1,1,0,16'h0122,2,1,0)));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_o0", 32'(o0), 32'h0);
    chk("rst_mid_cnt", 32'(mc0), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_tag", 32'(twe0), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_rdy = 1'b0;
    req = 1'b1; hit = 1'b0; miss_addr = 16'h0200;
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("restart_word0", 32'(o0), 32'(ov(1,1,1,0,16'h0200,0,0,0)));
    chk("restart_cnt", 32'(mc0), 32'h1);

    // Five back-to-back refills: the 2-bit counter saturates at 3.
    do_reset();
    for (int m = 0; m < 5; m++) begin
      logic [15:0] e2;
      e2 = (m < 3) ? 16'(m + 1) : 16'd3;
      req = 1'b1; hit = 1'b0; miss_addr = 16'(16'h0100 + 16'(m * 4));
      @(negedge clk);
      req = 1'b0; mem_rdy = 1'b1;
      #1;
      chk($sformatf("sat_cnt2_m%0d", m), 32'(mc2), 32'(e2));
      chk($sformatf("sat_cnt0_m%0d", m), 32'(mc0), 32'(m + 1));
      for (int w = 0; w < 4; w++) @(negedge clk);
      mem_rdy = 1'b0;
    end
    #1;
    chk("sat_idle", 32'(o2), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Parametrised miss/refill controller for the pipeline's L1 caches.
- Generalises the single-word, read-only miss FSM in three ways: multi-word line refill with a word counter, an optional dirty-victim writeback mode (D-cache use), and a saturating miss counter.
- Sits between one cache array (tag/data) and the shared memory port.
- Yields the port to the other cache's controller via a busy/other_busy handshake.

Parameters:
WORDS_PER_LINE, 4, words per cache line; power of two, at least 2; OFF_W = log2(WORDS_PER_LINE)
ADDR_W, 16, word-address width
WRITEBACK, 0, 1 enables dirty-victim writeback before refill (D-cache); 0 means refill only (I-cache)
CNT_W, 16, width of the saturating miss counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  cache access valid this cycle
hit  in  1  tag match for current access
dirty  in  1  victim line dirty (ignored when WRITEBACK=0)
miss_addr  in  ADDR_W  word address of current access
victim_addr  in  ADDR_W  word address of victim line (ignored when WRITEBACK=0)
other_busy  in  1  other cache controller owns memory
mem_rdy  in  1  memory completed current word (read data valid / write accepted)
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable (always 0 when WRITEBACK=0)
mem_addr  out  ADDR_W  memory word address
word_sel  out  OFF_W  line word index for cache data read/write
cache_we  out  1  write refill word into data array
tag_we  out  1  write tag/valid, clear dirty
stall  out  1  stall pipeline
busy  out  1  this controller owns memory (feeds other side's other_busy)
miss_cnt  out  CNT_W  saturating count of accepted misses

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset forces state IDLE, word counter 0, latched addresses 0, miss_cnt 0.
  - While rst_n is low, every output is 0.
  - Reset mid-refill abandons the transfer; no tag_we is issued.
- State registers: state, cnt (OFF_W bits), line_q and victim_q (ADDR_W-OFF_W bits each).
  - Line bases are latched when a miss is accepted.
  - Later changes on miss_addr/victim_addr are ignored until IDLE.
- Line base: line_q = miss_addr[ADDR_W-1:OFF_W]; mem_addr = {base, cnt}; word_sel = cnt.
- States:
  - IDLE: all outputs 0 except miss_cnt.
    - A miss is accepted when req && !hit && !other_busy.
    - On accept, in the same cycle (combinational): stall=1, busy=1, latch bases, cnt<=0, miss_cnt increments unless all-ones.
    - Next state is WB if WRITEBACK && dirty, else FILL.
    - req && !hit && other_busy: stall=1, stay IDLE, miss not counted (retried each cycle).
    - !req or hit: no stall.
  - WB: stall=1, busy=1, mem_we=1, mem_addr={victim_q,cnt}, word_sel=cnt.
    - On mem_rdy: cnt++.
    - On mem_rdy at cnt=WORDS_PER_LINE-1: cnt<=0, go FILL.
  - FILL: stall=1, busy=1, mem_re=1, mem_addr={line_q,cnt}.
    - On mem_rdy: cache_we=1 that cycle, cnt++.
    - On mem_rdy at the last word: cache_we=1 and tag_we=1 together, go IDLE.
- Stall drops the cycle after the last word, so the replayed access hits.
- mem_re and mem_we are never both 1. busy is 1 in WB and FILL and in the accept cycle.
- Counter wraps modulo WORDS_PER_LINE only at the exit of WB/FILL.
- mem_rdy in IDLE is ignored.
- req deasserting mid-refill does not abort; the line completes.
- miss_cnt saturates at 2^CNT_W-1.

Test Plan:
- WRITEBACK=0, W=4: miss at addr 0x0123, mem_rdy on cycles 3,5,6,9 after accept -> mem_addr 0x0120..0x0123 in order; cache_we pulses 4 times with word_sel 0..3; tag_we only with the 4th; stall high from the accept cycle through the 4th mem_rdy cycle; miss_cnt=1.
- Miss while other_busy=1 for 5 cycles -> stall=1, mem_re=0, busy=0, miss_cnt unchanged; accept on cycle 6.
- WRITEBACK=1, dirty=1, victim 0x0440, miss 0x0810 -> 4 mem_we writes to 0x0440..0x0443, then 4 mem_re reads to 0x0810..0x0813; mem_re and mem_we never both high; one tag_we.
- Hit traffic, and the dirty input with WRITEBACK=0 -> no stall, no memory activity; dirty has no effect.
- rst_n low during FILL at cnt=2 -> all outputs 0 immediately, tag_we never asserted; a miss after release refills from word 0 and miss_cnt restarts at 1.
- CNT_W=2: 5 misses -> miss_cnt reads 1,2,3,3,3.
